// File: rtl/usb_tx_mass_seq_if.sv
// usb_tx_mass_seq_if: host byte stream in, 32-bit keep/last beat stream out
interface usb_tx_mass_seq_if;
  logic        rx_tvalid;
  logic [7:0]  rx_tdata;
  logic        rx_tready;
  logic        tx_tready;
  logic        tx_tvalid;
  logic [31:0] tx_tdata;
  logic [3:0]  tx_tkeep;
  logic        tx_tlast;
  modport slave (input rx_tvalid, rx_tdata, tx_tready, output rx_tready, tx_tvalid, tx_tdata, tx_tkeep, tx_tlast);
  modport master (output rx_tvalid, rx_tdata, tx_tready, input rx_tready, tx_tvalid, tx_tdata, tx_tkeep, tx_tlast);
endinterface

// File: rtl/usb_tx_mass_seq.sv
// usb_tx_mass_seq: takes a 4-byte LE length header, then streams that many incrementing pattern bytes
module usb_tx_mass_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic clk,
  input  logic rstn,
  usb_tx_mass_seq_if.slave bus,
  output logic busy,
  output logic done,
  output logic hdr_timeout
);
  typedef enum logic {COLLECT, SEND} state_t;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  state_t state, state_nx;
  logic [1:0] hcnt;
  logic [23:0] len;
  logic [31:0] remaining, idle, hdr_len, data;
  logic [7:0] sent;
  logic [3:0] keep;
  logic send, acc, hs, last, timed_out;
  assign send = state == SEND;
  assign acc = !send && bus.rx_tvalid;
  assign hs = send && bus.tx_tready;
  // len fills from the top so the first byte ends up as the LSB after three shifts
  assign hdr_len = {bus.rx_tdata, len};
  assign last = remaining <= 32'd4;
  assign keep = !last ? 4'hf : remaining[2] ? 4'hf : remaining[1:0] == 2'd3 ? 4'h7 : remaining[1:0] == 2'd2 ? 4'h3 : 4'h1;
  assign timed_out = TIMEOUT_CYCLES != 0 && !send && hcnt != 2'd0 && !acc && idle == TO_LAST;
  always_comb begin
    state_nx = (acc && hcnt == 2'd3 && hdr_len != 32'd0) ? SEND : (hs && last) ? COLLECT : state;
  end
  always_comb begin
    data = '0;
    for (int i = 0; i < 4; i++)
      data[8*i +: 8] = (send && keep[i]) ? sent + 8'(i) : 8'h00;
  end
  assign bus.rx_tready = !send;
  assign bus.tx_tvalid = send;
  assign bus.tx_tdata = data;
  assign bus.tx_tkeep = send ? keep : 4'h0;
  assign bus.tx_tlast = send && last;
  assign busy = send;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= COLLECT;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hcnt <= '0;
      len <= '0;
      remaining <= '0;
      sent <= '0;
      idle <= '0;
      done <= 1'b0;
      hdr_timeout <= 1'b0;
    end else begin
      done <= (acc && hcnt == 2'd3 && hdr_len == 32'd0) || (hs && last);
      hdr_timeout <= timed_out;
      if (acc) begin
        hcnt <= hcnt + 2'd1;
        len <= {bus.rx_tdata, len[23:8]};
        idle <= '0;
        if (hcnt == 2'd3 && hdr_len != 32'd0) begin
          remaining <= hdr_len;
          sent <= '0;
        end
      end else if (timed_out) begin
        hcnt <= '0;
        idle <= '0;
      end else if (!send && hcnt != 2'd0) begin
        idle <= idle + 32'd1;
      end
      if (hs) begin
        sent <= sent + 8'd4;
        remaining <= remaining - 32'd4;
      end
    end
  end
endmodule

// File: tb/tb_usb_tx_mass_seq.sv
// tb_usb_tx_mass_seq: directed headers against a transfer-level beat/done/timeout model
module tb_usb_tx_mass_seq;
  localparam int TC = 16;
  typedef struct packed {logic [31:0] d; logic [3:0] k; logic l;} beat_t;
  logic clk, rstn, busy, done, hdr_timeout;
  bit rnd;
  int errs, checks, to_cnt;
  beat_t mq[$], blog[$];
  logic [7:0] hdr[$];
  int idle;
  bit done_exp, to_exp;
  usb_tx_mass_seq_if bus();
  usb_tx_mass_seq #(.TIMEOUT_CYCLES(TC)) dut (.clk(clk), .rstn(rstn), .bus(bus), .busy(busy), .done(done), .hdr_timeout(hdr_timeout));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endfunction
  // Expected beats of an n-byte transfer: byte k of the transfer carries k mod 256
  function automatic void build(int unsigned n);
    for (int unsigned off = 0; off < n; off += 4) begin
      beat_t b;
      int unsigned c;
      c = (n - off >= 4) ? 4 : n - off;
      b.d = '0;
      for (int unsigned i = 0; i < c; i++) b.d[8*i +: 8] = 8'(off + i);
      b.k = 4'((1 << c) - 1);
      b.l = off + 4 >= n;
      mq.push_back(b);
    end
  endfunction
  always @(posedge clk) begin
    #1;
    bus.tx_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  always @(negedge clk) begin
    if (!rstn) begin
      mq.delete();
      hdr.delete();
      idle = 0;
      done_exp = 0;
      to_exp = 0;
      chk("rst_tvalid", bus.tx_tvalid, 0);
      chk("rst_tdata", bus.tx_tdata, 0);
      chk("rst_tkeep", bus.tx_tkeep, 0);
      chk("rst_tlast", bus.tx_tlast, 0);
      chk("rst_rx_tready", bus.rx_tready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_hdr_timeout", hdr_timeout, 0);
    end else begin
      chk("tx_tvalid", bus.tx_tvalid, mq.size() != 0);
      chk("busy", busy, mq.size() != 0);
      chk("rx_tready", bus.rx_tready, mq.size() == 0);
      chk("done", done, done_exp);
      chk("hdr_timeout", hdr_timeout, to_exp);
      if (hdr_timeout) to_cnt++;
      if (mq.size() != 0) begin
        chk("tx_tdata", bus.tx_tdata, mq[0].d);
        chk("tx_tkeep", bus.tx_tkeep, mq[0].k);
        chk("tx_tlast", bus.tx_tlast, mq[0].l);
      end else begin
        chk("idle_tdata", bus.tx_tdata, 0);
        chk("idle_tkeep", bus.tx_tkeep, 0);
      end
      done_exp = 0;
      to_exp = 0;
      if (mq.size() != 0) begin
        if (bus.tx_tready) begin
          beat_t b;
          blog.push_back({bus.tx_tdata, bus.tx_tkeep, bus.tx_tlast});
          b = mq.pop_front();
          done_exp = b.l;
        end
      end else if (bus.rx_tvalid) begin
        hdr.push_back(bus.rx_tdata);
        idle = 0;
        if (hdr.size() == 4) begin
          logic [31:0] n;
          n = {hdr[3], hdr[2], hdr[1], hdr[0]};
          hdr.delete();
          if (n == 0) done_exp = 1;
          else build(n);
        end
      end else if (hdr.size() != 0) begin
        idle++;
        if (idle == TC) begin
          hdr.delete();
          idle = 0;
          to_exp = 1;
        end
      end
    end
  end
  task automatic send_hdr(input logic [31:0] n);
    for (int i = 0; i < 4; i++) begin
      bus.rx_tvalid = 1'b1;
      bus.rx_tdata = n[8*i +: 8];
      @(posedge clk);
      #1;
    end
    bus.rx_tvalid = 1'b0;
  endtask
  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int k = 0; k < 4000; k++) begin
      if (mq.size() == 0 && !bus.tx_tvalid) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("xfer_finished", ok, 1);
  endtask
  task automatic chk_beat(string n, int idx, logic [31:0] d, logic [3:0] k, logic l);
    if (idx < blog.size()) begin
      chk({n, "_data"}, blog[idx].d, d);
      chk({n, "_keep"}, blog[idx].k, k);
      chk({n, "_last"}, blog[idx].l, l);
    end else chk({n, "_missing"}, blog.size(), idx + 1);
  endtask
  initial begin
    int base;
    rstn = 1'b0;
    bus.rx_tvalid = 1'b0;
    bus.rx_tdata = 8'h00;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    base = blog.size();
    send_hdr(32'd8);
    chk("first_beat_valid", bus.tx_tvalid, 1);
    wait_done();
    chk("len8_done", done, 1);
    chk("len8_beats", blog.size() - base, 2);
    chk_beat("len8_b0", base, 32'h03020100, 4'hf, 1'b0);
    chk_beat("len8_b1", base + 1, 32'h07060504, 4'hf, 1'b1);
    base = blog.size();
    send_hdr(32'd5);
    wait_done();
    chk_beat("len5_b0", base, 32'h03020100, 4'hf, 1'b0);
    chk_beat("len5_b1", base + 1, 32'h00000004, 4'h1, 1'b1);
    send_hdr(32'd0);
    chk("len0_done", done, 1);
    chk("len0_tvalid", bus.tx_tvalid, 0);
    chk("len0_rx_tready", bus.rx_tready, 1);
    base = blog.size();
    send_hdr(32'd4);
    wait_done();
    chk_beat("len4", base, 32'h03020100, 4'hf, 1'b1);
    rnd = 1;
    base = blog.size();
    send_hdr(32'd256);
    wait_done();
    rnd = 0;
    chk("len256_beats", blog.size() - base, 64);
    chk_beat("len256_b63", base + 63, 32'hfffefdfc, 4'hf, 1'b1);
    to_cnt = 0;
    bus.rx_tvalid = 1'b1;
    bus.rx_tdata = 8'h03;
    @(posedge clk);
    #1 bus.rx_tdata = 8'h00;
    @(posedge clk);
    #1 bus.rx_tvalid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("timeout_pulses", to_cnt, 1);
    base = blog.size();
    send_hdr(32'd3);
    wait_done();
    chk_beat("len3", base, 32'h00020100, 4'h7, 1'b1);
    base = blog.size();
    send_hdr(32'h40);
    for (int k = 0; k < 100 && blog.size() < base + 5; k++) @(posedge clk);
    chk("five_beats", blog.size() - base, 5);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_tvalid", bus.tx_tvalid, 0);
    chk("arst_tdata", bus.tx_tdata, 0);
    chk("arst_tkeep", bus.tx_tkeep, 0);
    chk("arst_tlast", bus.tx_tlast, 0);
    chk("arst_busy", busy, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    chk("arst_rx_tready", bus.rx_tready, 1);
    base = blog.size();
    send_hdr(32'd4);
    wait_done();
    chk_beat("post_rst", base, 32'h03020100, 4'hf, 1'b1);
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
